demux_8para8: RTL
=================

DEMUX_8PARA8 -- requirements
Module: demux_8para8

Interface
REQ-001 Parameter WIDTH, default 8, data width of input and both outputs.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, one clock; reset is asynchronous and active-low.
REQ-004 E  input  WIDTH  input data word.
REQ-005 E_VALID  input  1  input word present.
REQ-006 E_READY  output  1  block accepts input this cycle.
REQ-007 SLCT  input  1  destination select, sampled with E: 0 -> A, 1 -> B.
REQ-008 SA  output  WIDTH  output A data.
REQ-009 SA_VALID  output  1  output A holds a word.
REQ-010 SA_READY  input  1  consumer A takes word.
REQ-011 SB  output  WIDTH  output B data.
REQ-012 SB_VALID  output  1  output B holds a word.
REQ-013 SB_READY  input  1  consumer B takes word.
REQ-014 CNT_A, CNT_B  output  8  delivered-word counters, present only with DEMUX_COUNT_EN.

Function
REQ-015 Each output has one holding register (data + full flag); SA/SB/SA_VALID/SB_VALID come directly from registers, with no combinational path from E.
REQ-016 Input handshake: accept = E_VALID && E_READY.
REQ-017 E_READY = SLCT ? (!B_full || SB_READY) : (!A_full || SA_READY); combinational from current SLCT and the selected output's state only.
REQ-018 On accept, the word loads into the holding register selected by SLCT and sets its full flag; latency is exactly 1 cycle from accept to VALID.
REQ-019 Output handshake: a word is delivered when SX_VALID && SX_READY; the full flag clears at the next edge unless a new accept targets the same output in the same cycle.
REQ-020 Simultaneous deliver and accept on the same output: the register loads the new word, VALID stays 1, and throughput is 1 word/cycle with no bubble.
REQ-021 The non-selected output is unaffected by accept; it may deliver in the same cycle, independently.
REQ-022 Stall: while SX_VALID=1 and SX_READY=0, SX holds its value and SX_VALID stays 1; E_READY=0 while SLCT points at that output.
REQ-023 SLCT changes while stalled are legal; E_READY re-evaluates immediately for the new destination. No word is lost, duplicated or reordered per output.
REQ-024 Holding-register data updates only on accept; otherwise it retains its value, including after delivery.
REQ-025 E_VALID=0: no state change except delivery-driven clearing of full flags.

Reset
REQ-026 RST_N=0 asynchronously clears SA, SB to 0 and SA_VALID, SB_VALID to 0 (CNT_A, CNT_B to 0 when present).
REQ-027 Reset mid-operation discards held words; E_READY=1 for both SLCT values while reset is held and after release.
REQ-028 The first accept is possible on the first rising edge after RST_N deasserts.

Configuration
REQ-029 Macro DEMUX_COUNT_EN: when defined, CNT_A/CNT_B ports exist and each increments by 1 on every delivery of its output, wrapping 255 -> 0; when undefined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-030 Reset, then E=8'hA5, SLCT=0, E_VALID=1 for 1 cycle -> next cycle SA=8'hA5, SA_VALID=1, SB_VALID=0.
REQ-031 SA_READY=0 with A full, SLCT=0, E=8'h11 valid -> E_READY=0, SA unchanged; switch SLCT=1 -> E_READY=1, SB=8'h11 next cycle.
REQ-032 Both READY=1, stream 8'h00..8'h0F alternating SLCT every cycle -> A receives evens, B receives odds, in order, 1 word/cycle, no gaps.
REQ-033 Assert RST_N=0 mid-stream with both outputs full -> SA_VALID=SB_VALID=0 and SA=SB=0 immediately, without a clock edge.
REQ-034 With DEMUX_COUNT_EN, deliver 257 words to B -> CNT_B=1 and CNT_A=0.

Source files
------------

// File: rtl/demux_8para8.sv
// 1-to-2 registered demultiplexer with valid/ready handshakes on all ports.
// Define DEMUX_COUNT_EN to add the cnt_a/cnt_b delivered-word counters.

module demux_8para8_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             rdy,
    output logic [WIDTH-1:0] q,
    output logic             vld
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]       cnt
`endif
);

    // A load in the same cycle as a delivery takes priority, so full stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (load) begin
            q   <= din;
            vld <= 1'b1;
        end else if (vld && rdy) begin
            vld <= 1'b0;
        end
    end

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (vld && rdy)
            cnt <= cnt + 8'd1;
    end
`endif

endmodule

module demux_8para8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] e,
    input  logic             e_valid,
    output logic             e_ready,
    input  logic             slct,
    output logic [WIDTH-1:0] sa,
    output logic             sa_valid,
    input  logic             sa_ready,
    output logic [WIDTH-1:0] sb,
    output logic             sb_valid,
    input  logic             sb_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
`endif
);

    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][WIDTH-1:0] q;
    logic [NUM_LANES-1:0]            vld;
    logic [NUM_LANES-1:0]            rdy;
    logic [NUM_LANES-1:0]            load;
    logic [NUM_LANES-1:0]            lane_free;
    logic                            accept;
`ifdef DEMUX_COUNT_EN
    logic [NUM_LANES-1:0][7:0]       cnt;
`endif

    assign rdy       = {sb_ready, sa_ready};
    // A lane can take a word if empty or if its current word leaves this cycle.
    assign lane_free = ~vld | rdy;
    assign e_ready   = lane_free[slct];
    assign accept    = e_valid && e_ready;
    assign load      = {accept && slct, accept && !slct};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_8para8_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[g]),
            .din   (e),
            .rdy   (rdy[g]),
            .q     (q[g]),
            .vld   (vld[g])
`ifdef DEMUX_COUNT_EN
            ,
            .cnt   (cnt[g])
`endif
        );
    end

    assign sa       = q[0];
    assign sb       = q[1];
    assign sa_valid = vld[0];
    assign sb_valid = vld[1];
`ifdef DEMUX_COUNT_EN
    assign cnt_a    = cnt[0];
    assign cnt_b    = cnt[1];
`endif

endmodule
